// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, access-size
// codes (same encoding decode produces) and the misalignment rule.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  // Size code 3 has no legal meaning, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      MEM_BYTE: bad = 1'b0;
      MEM_HALF: bad = off[0];
      MEM_WORD: bad = (off != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the memory stage.
// Ports:
//   st_off, st_size, st_data -> st_be, st_wdata : store byte enables and lane-replicated data
//   ld_off, ld_size, ld_unsigned, ld_rdata -> ld_data : extracted and extended load value
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_be    = 4'h0;
    st_wdata = st_data;
    case (st_size)
      MEM_BYTE: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_HALF: begin
        st_be    = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
      end
      MEM_WORD: begin
        st_be    = 4'hF;
        st_wdata = st_data;
      end
      default: begin
        st_be    = 4'h0;
        st_wdata = st_data;
      end
    endcase
  end

  assign shifted = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (ld_size)
      MEM_BYTE: ld_data = ld_unsigned ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      MEM_HALF: ld_data = ld_unsigned ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default:  ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues data-memory loads/stores on a req/gnt/rvalid bus,
// stalls upstream while an access is outstanding, and owns MEM/WB.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   EX_MEM_*             : instruction held in EX/MEM (held stable while MEM_stall)
//   dmem_*               : data-memory bus (req/we/addr/be/wdata out, gnt/rvalid/rdata in)
//   MEM_stall            : combinational, EX/MEM must hold
//   MEM_misaligned       : one-cycle pulse when a misaligned access is dropped
//   MEM_WB_*             : MEM/WB pipeline register
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MEM_IDLE | no access outstanding; new access requests combinationally
// MEM_REQ  | request asserted, waiting for dmem_gnt
// MEM_RESP | load granted, waiting for dmem_rvalid
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EX_MEM_alu_res,
  input  logic [31:0] EX_MEM_rs2_data,
  input  logic        EX_MEM_mem_read,
  input  logic        EX_MEM_mem_write,
  input  logic [1:0]  EX_MEM_mem_size,
  input  logic        EX_MEM_mem_unsigned,
  input  logic [1:0]  EX_MEM_wb_sel,
  input  logic        EX_MEM_vld,
  input  logic [4:0]  EX_MEM_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        MEM_stall,
  output logic        MEM_misaligned,
  output logic [31:0] MEM_WB_alu_res,
  output logic [31:0] MEM_WB_mem_dout,
  output logic [1:0]  MEM_WB_wb_sel,
  output logic        MEM_WB_vld,
  output logic [4:0]  MEM_WB_rd
);

  mem_state_e state, state_nxt;

  logic       access, misal;
  logic       req_c, stall_c, retire, load_done, capture, misal_pulse;
  logic [1:0] off_q, size_q;
  logic       uns_q;
  logic [3:0] st_be;
  logic [31:0] st_wdata, ld_data;

  assign access = EX_MEM_vld & (EX_MEM_mem_read | EX_MEM_mem_write);
  assign misal  = is_misaligned(EX_MEM_mem_size, EX_MEM_alu_res[1:0]);

  mem_align u_align (
    .st_off      (EX_MEM_alu_res[1:0]),
    .st_size     (EX_MEM_mem_size),
    .st_data     (EX_MEM_rs2_data),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_off      (off_q),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_rdata    (dmem_rdata),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_nxt;
  end

  // retire: load MEM/WB with the EX/MEM instruction; otherwise a bubble.
  always_comb begin
    state_nxt   = state;
    req_c       = 1'b0;
    stall_c     = 1'b0;
    retire      = 1'b0;
    load_done   = 1'b0;
    capture     = 1'b0;
    misal_pulse = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (!access) begin
          retire = 1'b1;
        end else if (misal) begin
          misal_pulse = 1'b1;
        end else begin
          req_c = 1'b1;
          if (dmem_gnt) begin
            capture = 1'b1;
            if (EX_MEM_mem_write) begin
              retire = 1'b1;
            end else begin
              stall_c   = 1'b1;
              state_nxt = MEM_RESP;
            end
          end else begin
            stall_c   = 1'b1;
            state_nxt = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        req_c = 1'b1;
        if (dmem_gnt) begin
          capture = 1'b1;
          if (EX_MEM_mem_write) begin
            retire    = 1'b1;
            state_nxt = MEM_IDLE;
          end else begin
            stall_c   = 1'b1;
            state_nxt = MEM_RESP;
          end
        end else begin
          stall_c = 1'b1;
        end
      end
      MEM_RESP: begin
        if (dmem_rvalid) begin
          retire    = 1'b1;
          load_done = 1'b1;
          state_nxt = MEM_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_nxt = MEM_IDLE;
    endcase
  end

  // Bus fields come straight from EX/MEM, which is frozen by the stall,
  // so they stay stable from request through grant.
  assign dmem_req   = req_c & ~rst;
  assign MEM_stall  = stall_c & ~rst;
  assign dmem_we    = EX_MEM_mem_write;
  assign dmem_addr  = {EX_MEM_alu_res[31:2], 2'b00};
  assign dmem_be    = EX_MEM_mem_write ? st_be : 4'hF;
  assign dmem_wdata = st_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      off_q           <= 2'b00;
      size_q          <= MEM_BYTE;
      uns_q           <= 1'b0;
      MEM_misaligned  <= 1'b0;
      MEM_WB_alu_res  <= 32'h0;
      MEM_WB_mem_dout <= 32'h0;
      MEM_WB_wb_sel   <= 2'b00;
      MEM_WB_vld      <= 1'b0;
      MEM_WB_rd       <= 5'd0;
    end else begin
      MEM_misaligned <= misal_pulse;
      if (capture) begin
        off_q  <= EX_MEM_alu_res[1:0];
        size_q <= EX_MEM_mem_size;
        uns_q  <= EX_MEM_mem_unsigned;
      end
      if (retire) begin
        MEM_WB_alu_res  <= EX_MEM_alu_res;
        MEM_WB_mem_dout <= load_done ? ld_data : 32'h0;
        MEM_WB_wb_sel   <= EX_MEM_wb_sel;
        MEM_WB_vld      <= EX_MEM_vld;
        MEM_WB_rd       <= EX_MEM_rd;
      end else begin
        MEM_WB_alu_res  <= 32'h0;
        MEM_WB_mem_dout <= 32'h0;
        MEM_WB_wb_sel   <= 2'b00;
        MEM_WB_vld      <= 1'b0;
        MEM_WB_rd       <= 5'd0;
      end
    end
  end

endmodule
